ysyx_22040365_ifu: RTL and testbench

Instruction fetch unit for the ysyx_22040365 core. Holds the PC, issues one 32-bit instruction fetch at a time to instruction memory over a valid/ready request plus valid-only response interface, and presents the fetched word with its PC to the decode stage through a one-entry output buffer. Taken branches and jumps from execute redirect the PC and flush in-flight work.

---
 rtl/ysyx_22040365_ifu.sv | 158 +++++++++++++++
 tb/tb_ysyx_22040365_ifu.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040365_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22040365_ifu
//
// Instruction fetch unit. Holds the PC and keeps at most one fetch in flight
// to instruction memory. The memory side uses a valid/ready request channel
// and a valid-only response channel. Each returned word is placed, together
// with its PC, in a one-entry buffer that the decode stage reads. A redirect
// from execute replaces the PC and flushes the buffer. If a request is already
// in flight when the redirect arrives, its response is marked for discard.
//
// Ports
//   clk             core clock
//   rst_n           synchronous, active-low reset
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request this cycle
//   imem_req_addr   fetch address (always the current pc)
//   imem_rsp_valid  instruction response valid
//   imem_rsp_data   fetched 32-bit instruction word
//   redirect_valid  one-cycle PC redirect from execute
//   redirect_pc     redirect target (low two bits are ignored)
//   inst_valid      buffered instruction available to decode
//   inst            buffered instruction word
//   inst_pc         PC of the buffered instruction
//   id_ready        decode consumes the buffered instruction this cycle
// ---------------------------------------------------------------------------
module ysyx_22040365_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        id_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] pc;
  logic        drop;

  logic        buf_free;
  logic        req_fire;
  logic        rsp_take;
  logic        rsp_load;
  logic [63:0] redirect_aligned;

  // The buffer can accept a new word if it is empty now, or if decode is
  // draining it this cycle. A request is only issued when this holds. Only
  // one response can come back per request, so the buffer never overflows.
  assign buf_free = !inst_valid || id_ready;

  // Handshake and response qualifiers. A response counts only while a
  // request is outstanding (S_WAIT). This makes any response that arrives
  // after a reset harmless. A response is written to the buffer only if it
  // is not stale and is not cancelled by a redirect on the same edge.
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_take = (state == S_WAIT) && imem_rsp_valid;
  assign rsp_load = rsp_take && !drop && !redirect_valid;

  // Instructions are 4-byte aligned, so the low two target bits are cleared.
  assign redirect_aligned = redirect_pc & ~64'd3;

  // State register. The redirect does not change the state transitions; it
  // only affects the pc, the drop flag and the buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. S_IDLE is a single cycle after reset. After that the
  // FSM alternates: it requests in S_REQ, then waits in S_WAIT for the one
  // response.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ:  if (req_fire) state_next = S_WAIT;
      S_WAIT: if (rsp_take) state_next = S_REQ;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic. A request is only presented when the buffer has room.
  // The address is the pc itself, so it stays stable across back-pressure
  // until a redirect changes the pc.
  always_comb begin
    imem_req_valid = (state == S_REQ) && buf_free;
    imem_req_addr  = pc;
  end

  // PC update. A redirect takes priority over normal sequential advance.
  // The pc advances only when a real word is written to the buffer, so the
  // value in pc is always the address of the next instruction to fetch.
  // Wrap-around at the top of the address space is the natural 64-bit
  // modulo behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_aligned;
    end else if (rsp_load) begin
      pc <= pc + 64'd4;
    end
  end

  // Drop flag. When set, the response to the in-flight request belongs to
  // the old path. The flag is set when a redirect happens while that
  // response is still to come: either the request is accepted on the
  // redirect edge, or the FSM is waiting and no response has arrived yet.
  // The flag is cleared when any response is consumed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop <= 1'b0;
    end else if (redirect_valid &&
                 (req_fire || ((state == S_WAIT) && !imem_rsp_valid))) begin
      drop <= 1'b1;
    end else if (rsp_take) begin
      drop <= 1'b0;
    end
  end

  // Output buffer. A redirect flushes it. A freshly loaded word wins over
  // consumption on the same edge. inst and inst_pc change only on a load,
  // so they stay stable while decode stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_valid <= 1'b0;
      inst       <= 32'd0;
      inst_pc    <= 64'd0;
    end else if (redirect_valid) begin
      inst_valid <= 1'b0;
    end else if (rsp_load) begin
      inst_valid <= 1'b1;
      inst       <= imem_rsp_data;
      inst_pc    <= pc;
    end else if (inst_valid && id_ready) begin
      inst_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040365_ifu
//
// Self-checking bench for the fetch unit. The bench contains a small memory
// that answers each accepted request after a configurable latency. It also
// keeps a transaction-level model of the fetch unit: the next fetch pc, an
// in-flight request with its stale mark, and the single buffered
// instruction. Directed scenarios pin the model with literal values.
// Randomized traffic, including redirects and mid-transaction resets, is
// then compared against the model on every cycle.
// ---------------------------------------------------------------------------
module tb_ysyx_22040365_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        id_ready;

  always #5 clk = ~clk;

  ysyx_22040365_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .id_ready       (id_ready)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: a fetch-level view of the unit.
  logic [63:0] m_pc;
  bit          m_started;
  bit          m_outstanding;
  bit          m_stale;
  bit          m_buf_valid;
  logic [31:0] m_buf_inst;
  logic [63:0] m_buf_pc;

  // Bench memory
  bit          mem_pending;
  int          mem_wait;
  logic [31:0] mem_data;

  // Stimulus knobs
  int          ready_pct;
  int          idready_pct;
  int          redirect_pct;
  int          lat_min;
  int          lat_max;
  bit          force_redirect;
  logic [63:0] force_redirect_pc;
  bit          fixed_data_en;
  logic [31:0] fixed_data;

  // Last observed cycle, plus logs of handshakes and delivered instructions
  logic        obs_req_valid;
  logic [63:0] obs_addr;
  logic        obs_inst_valid;
  logic [31:0] obs_inst;
  logic [63:0] obs_inst_pc;
  logic [63:0] hs_addrs[$];
  logic [63:0] del_pcs[$];

  function automatic void checkVal(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void modelReset();
    m_pc          = RESET_PC;
    m_started     = 0;
    m_outstanding = 0;
    m_stale       = 0;
    m_buf_valid   = 0;
    m_buf_inst    = 32'd0;
    m_buf_pc      = 64'd0;
  endfunction

  // Drive this cycle's inputs from the memory state and the knobs.
  task automatic applyStimulus(input bit rst_val);
    rst_n          = rst_val;
    imem_rsp_valid = mem_pending && (mem_wait == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_data : $urandom;
    imem_req_ready = !mem_pending && ($urandom_range(99) < ready_pct);
    id_ready       = $urandom_range(99) < idready_pct;
    if (force_redirect) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_redirect_pc;
      force_redirect = 0;
    end else if ($urandom_range(99) < redirect_pct) begin
      redirect_valid = 1'b1;
      if ($urandom_range(3) == 0)
        redirect_pc = {32'hFFFF_FFFF, 32'hFFFF_FFF0 | ($urandom & 32'hF)};
      else
        redirect_pc = {$urandom, $urandom};
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = {$urandom, $urandom};
    end
  endtask

  // Compare outputs with the model, then advance the model and memory.
  task automatic checkOutput();
    bit exp_req;
    bit accepted;
    exp_req = m_started && !m_outstanding && (!m_buf_valid || id_ready);
    checkVal("req_valid", 64'(imem_req_valid), 64'(exp_req));
    if (exp_req) checkVal("req_addr", imem_req_addr, m_pc);
    checkVal("inst_valid", 64'(inst_valid), 64'(m_buf_valid));
    if (m_buf_valid) begin
      checkVal("inst", 64'(inst), 64'(m_buf_inst));
      checkVal("inst_pc", inst_pc, m_buf_pc);
    end

    obs_req_valid  = imem_req_valid;
    obs_addr       = imem_req_addr;
    obs_inst_valid = inst_valid;
    obs_inst       = inst;
    obs_inst_pc    = inst_pc;
    if (imem_req_valid && imem_req_ready) hs_addrs.push_back(imem_req_addr);
    if (rst_n && inst_valid && id_ready) del_pcs.push_back(inst_pc);

    accepted = exp_req && imem_req_ready;
    if (!rst_n) begin
      modelReset();
    end else if (redirect_valid) begin
      m_pc        = {redirect_pc[63:2], 2'b00};
      m_buf_valid = 0;
      if (accepted) begin
        m_outstanding = 1;
        m_stale       = 1;
      end else if (m_outstanding) begin
        if (imem_rsp_valid) begin
          m_outstanding = 0;
          m_stale       = 0;
        end else begin
          m_stale = 1;
        end
      end
      m_started = 1;
    end else begin
      if (m_buf_valid && id_ready) m_buf_valid = 0;
      if (m_outstanding && imem_rsp_valid) begin
        m_outstanding = 0;
        if (m_stale) begin
          m_stale = 0;
        end else begin
          m_buf_valid = 1;
          m_buf_inst  = imem_rsp_data;
          m_buf_pc    = m_pc;
          m_pc        = m_pc + 64'd4;
        end
      end
      if (accepted) m_outstanding = 1;
      m_started = 1;
    end

    if (imem_rsp_valid) mem_pending = 0;
    else if (mem_pending && mem_wait > 0) mem_wait--;
    if (imem_req_valid && imem_req_ready) begin
      mem_pending = 1;
      mem_wait    = $urandom_range(lat_max - 1, lat_min - 1);
      mem_data    = fixed_data_en ? fixed_data : $urandom;
    end
  endtask

  task automatic cycle(input bit rst_val);
    @(posedge clk);
    #1;
    applyStimulus(rst_val);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    cycle(0);
    cycle(0);
    mem_pending = 0;
    hs_addrs.delete();
    del_pcs.delete();
  endtask

  // First cycle after reset release: idle, empty buffer, cleared registers.
  task automatic resetChecks();
    cycle(1);
    checkVal("rst_req_valid", 64'(obs_req_valid), 64'd0);
    checkVal("rst_inst_valid", 64'(obs_inst_valid), 64'd0);
    checkVal("rst_inst", 64'(obs_inst), 64'd0);
    checkVal("rst_inst_pc", obs_inst_pc, 64'd0);
  endtask

  task automatic setKnobs(input int rdy, input int idr, input int lmin, input int lmax);
    ready_pct    = rdy;
    idready_pct  = idr;
    lat_min      = lmin;
    lat_max      = lmax;
    redirect_pct = 0;
  endtask

  initial begin
    int valid_cnt;
    rst_n = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; id_ready = 0;
    force_redirect = 0; force_redirect_pc = 0; fixed_data_en = 0; fixed_data = 0;
    mem_pending = 0; mem_wait = 0; mem_data = 0;
    setKnobs(100, 100, 1, 1);
    repeat (2) @(posedge clk);
    modelReset();

    // Streaming with single-cycle memory
    doReset();
    resetChecks();
    valid_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1);
      if (obs_inst_valid) valid_cnt++;
    end
    checkVal("stream_hs_count", 64'(hs_addrs.size() >= 3), 64'd1);
    if (hs_addrs.size() >= 3) begin
      checkVal("stream_addr0", hs_addrs[0], 64'h0000_0000_8000_0000);
      checkVal("stream_addr1", hs_addrs[1], 64'h0000_0000_8000_0004);
      checkVal("stream_addr2", hs_addrs[2], 64'h0000_0000_8000_0008);
    end
    checkVal("stream_del_count", 64'(del_pcs.size() >= 3), 64'd1);
    if (del_pcs.size() >= 3) begin
      checkVal("stream_pc0", del_pcs[0], 64'h0000_0000_8000_0000);
      checkVal("stream_pc1", del_pcs[1], 64'h0000_0000_8000_0004);
      checkVal("stream_pc2", del_pcs[2], 64'h0000_0000_8000_0008);
    end
    checkVal("stream_valid_cycles", 64'(valid_cnt), 64'd3);

    // Decode stall holds the buffer and blocks new requests
    setKnobs(100, 0, 1, 1);
    fixed_data_en = 1; fixed_data = 32'h0000_0013;
    doReset();
    resetChecks();
    cycle(1);
    cycle(1);
    for (int i = 0; i < 5; i++) begin
      cycle(1);
      checkVal("stall_inst_valid", 64'(obs_inst_valid), 64'd1);
      checkVal("stall_req_valid", 64'(obs_req_valid), 64'd0);
      checkVal("stall_inst_pc", obs_inst_pc, 64'h0000_0000_8000_0000);
      checkVal("stall_inst", 64'(obs_inst), 64'h0000_0013);
    end
    idready_pct = 100;
    cycle(1);
    checkVal("release_req_valid", 64'(obs_req_valid), 64'd1);
    checkVal("release_addr", obs_addr, 64'h0000_0000_8000_0004);
    fixed_data_en = 0;

    // Memory back-pressure holds the request
    setKnobs(0, 100, 1, 1);
    doReset();
    resetChecks();
    for (int i = 0; i < 3; i++) begin
      cycle(1);
      checkVal("bp_req_valid", 64'(obs_req_valid), 64'd1);
      checkVal("bp_addr", obs_addr, 64'h0000_0000_8000_0000);
    end
    checkVal("bp_no_accept", 64'(hs_addrs.size()), 64'd0);
    ready_pct = 100;
    cycle(1);
    cycle(1);
    checkVal("bp_single_accept", 64'(hs_addrs.size()), 64'd1);

    // Redirect while waiting: the late response is dropped
    setKnobs(100, 100, 3, 3);
    fixed_data_en = 1; fixed_data = 32'h0010_0093;
    doReset();
    resetChecks();
    cycle(1);
    force_redirect = 1; force_redirect_pc = 64'h0000_0000_8000_0100;
    cycle(1);
    for (int i = 0; i < 2; i++) begin
      cycle(1);
      checkVal("drop_inst_valid", 64'(obs_inst_valid), 64'd0);
      checkVal("drop_req_valid", 64'(obs_req_valid), 64'd0);
    end
    cycle(1);
    checkVal("drop_after_inst_valid", 64'(obs_inst_valid), 64'd0);
    checkVal("drop_after_req_valid", 64'(obs_req_valid), 64'd1);
    checkVal("drop_after_addr", obs_addr, 64'h0000_0000_8000_0100);
    fixed_data_en = 0;

    // Redirect with a response on the same edge, then a redirect that flushes a full buffer
    setKnobs(100, 0, 1, 1);
    doReset();
    resetChecks();
    cycle(1);
    force_redirect = 1; force_redirect_pc = 64'h0000_0000_8000_0203;
    cycle(1);
    cycle(1);
    checkVal("rsp_redir_inst_valid", 64'(obs_inst_valid), 64'd0);
    checkVal("rsp_redir_req_valid", 64'(obs_req_valid), 64'd1);
    checkVal("rsp_redir_addr", obs_addr, 64'h0000_0000_8000_0200);
    cycle(1);
    force_redirect = 1; force_redirect_pc = 64'h0000_0000_8000_0300;
    cycle(1);
    checkVal("flush_pre_inst_valid", 64'(obs_inst_valid), 64'd1);
    checkVal("flush_pre_inst_pc", obs_inst_pc, 64'h0000_0000_8000_0200);
    cycle(1);
    checkVal("flush_inst_valid", 64'(obs_inst_valid), 64'd0);
    checkVal("flush_req_valid", 64'(obs_req_valid), 64'd1);
    checkVal("flush_addr", obs_addr, 64'h0000_0000_8000_0300);

    // PC wrap at the top of the address space
    setKnobs(100, 100, 1, 1);
    doReset();
    force_redirect = 1; force_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    resetChecks();
    cycle(1);
    checkVal("wrap_first_addr", obs_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1);
    cycle(1);
    checkVal("wrap_inst_valid", 64'(obs_inst_valid), 64'd1);
    checkVal("wrap_inst_pc", obs_inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkVal("wrap_next_addr", obs_addr, 64'd0);

    // Randomized traffic with redirects and occasional mid-transaction resets
    setKnobs(70, 70, 1, 4);
    redirect_pct = 4;
    doReset();
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(99) >= 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
